// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write/read controllers: state encoding and default sizes.
package fifo_ctrl_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_NUM_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } fifo_state_e;

endpackage

// File: rtl/read_control_logic_if.sv
// FIFO read side plus sink write bus of the drain stage.
// master = the read controller, slave = FIFO/sink environment.
interface read_control_logic_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              rdempty_i;
  logic [DATA_W-1:0] rddata_i;
  logic              sink_ready_i;
  logic              rdreq_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              done_o;
  logic [31:0]       checksum_o;

  modport master (
    input  rdempty_i, rddata_i, sink_ready_i,
    output rdreq_o, mem_we_o, mem_addr_o, mem_data_o, done_o, checksum_o
  );

  modport slave (
    output rdempty_i, rddata_i, sink_ready_i,
    input  rdreq_o, mem_we_o, mem_addr_o, mem_data_o, done_o, checksum_o
  );
endinterface

// File: rtl/read_control_logic_checksum_acc.sv
// Running 32-bit modulo-2^32 sum of written words; only built when READ_CHECKSUM_EN is defined.
`ifdef READ_CHECKSUM_EN
module checksum_acc #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [31:0]       sum_o
);

  logic [31:0] sum_q;

  // accumulator register, synchronous clear has priority
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      sum_q <= 32'h0;
    end else if (en_i) begin
      sum_q <= sum_q + 32'(data_i);
    end else begin
      sum_q <= sum_q;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/read_control_logic.sv
// Drain stage: pops words from a normal-mode FIFO and writes them sequentially to a sink.
// Optional running checksum under macro READ_CHECKSUM_EN; checksum_o reads 0 otherwise.
module read_control_logic
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  read_control_logic_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  fifo_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              wr_done_s;

  // next-state and datapath update
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = done_q;
    wr_done_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (!bus.rdempty_i) state_d = ST_READ;
        else                state_d = state_q;
      end
      ST_READ:  state_d = ST_LATCH;
      ST_LATCH: begin
        data_d  = bus.rddata_i;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.sink_ready_i) begin
          wr_done_s = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            // rdempty is sampled only here, after the address step
            addr_d  = addr_q + ADDR_W'(1);
            state_d = bus.rdempty_i ? ST_WAIT : ST_READ;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bus.rdreq_o    = (state_q == ST_READ);
  assign bus.mem_we_o   = (state_q == ST_WRITE);
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign bus.done_o     = done_q;

`ifdef READ_CHECKSUM_EN
  logic [31:0] sum_s;

  checksum_acc #(.DATA_W(DATA_W)) u_checksum_acc (
    .clk_i   (clk_i),
    .clear_i (!reset_n_i),
    .en_i    (wr_done_s),
    .data_i  (data_q),
    .sum_o   (sum_s)
  );

  assign bus.checksum_o = sum_s;
`else
  assign bus.checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_read_control_logic.sv
// Directed bench for read_control_logic: FIFO/sink models, write log, hand-computed expectations.
module tb_read_control_logic;

  localparam int DW = 32;
  localparam int AW = 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  read_control_logic_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  read_control_logic_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  read_control_logic #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(256)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
  );

  read_control_logic #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(4)) dut_cs (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus2)
  );

`ifdef READ_CHECKSUM_EN
  localparam logic [31:0] EXP_CS_MAIN  = 32'h0000_7F80;
  localparam logic [31:0] EXP_CS_SMALL = 32'h0000_0031;
`else
  localparam logic [31:0] EXP_CS_MAIN  = 32'h0;
  localparam logic [31:0] EXP_CS_SMALL = 32'h0;
`endif

  // main FIFO model: normal mode, data appears the cycle after rdreq
  logic [31:0] fifo_mem [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [31:0] rd_q   = 32'h0;
  int          underflow_n = 0;
  logic        sink_rdy = 1'b1;

  assign bus.rdempty_i    = (rd_ptr == wr_ptr);
  assign bus.rddata_i     = rd_q;
  assign bus.sink_ready_i = sink_rdy;

  always @(posedge clk) begin
    if (bus.rdreq_o) begin
      rd_q   <= fifo_mem[rd_ptr[8:0]];
      rd_ptr <= rd_ptr + 1;
      if (rd_ptr == wr_ptr) underflow_n <= underflow_n + 1;
    end
  end

  // four-word FIFO for the small instance
  int          cs_ptr = 0;
  logic [31:0] cs_q   = 32'h0;
  assign bus2.rdempty_i    = (cs_ptr >= 4);
  assign bus2.rddata_i     = cs_q;
  assign bus2.sink_ready_i = 1'b1;

  always @(posedge clk) begin
    if (bus2.rdreq_o) begin
      case (cs_ptr)
        0:       cs_q <= 32'hFFFF_FFFF;
        1:       cs_q <= 32'h0000_0002;
        2:       cs_q <= 32'h0000_0010;
        default: cs_q <= 32'h0000_0020;
      endcase
      cs_ptr <= cs_ptr + 1;
    end
  end

  // log of completed sink writes on the main instance
  logic [AW-1:0] log_addr [0:399];
  logic [31:0]   log_data [0:399];
  int            log_cyc  [0:399];
  int            wr_n = 0;
  int            cyc  = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we_o && bus.sink_ready_i && wr_n < 400) begin
      log_addr[wr_n] <= bus.mem_addr_o;
      log_data[wr_n] <= bus.mem_data_o;
      log_cyc[wr_n]  <= cyc;
      wr_n           <= wr_n + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int t;
    int bad;
    int stable;

    for (int i = 0; i < 10; i++) fifo_mem[i] = 32'h1000_0000 + 32'(i);
    wr_ptr = 10;

    // reset hold with a non-empty FIFO
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdreq", bus.rdreq_o, 1'b0);
    check_eq("rst_we", bus.mem_we_o, 1'b0);
    check_eq("rst_addr", bus.mem_addr_o, 10'd0);
    check_eq("rst_data", bus.mem_data_o, 32'h0);
    check_eq("rst_done", bus.done_o, 1'b0);
    check_eq("rst_cs", bus.checksum_o, 32'h0);
    reset_n = 1'b1;
    check_eq("rel_cyc1_rdreq", bus.rdreq_o, 1'b0);
    @(negedge clk);
    check_eq("rel_cyc2_rdreq", bus.rdreq_o, 1'b1);

    // backpressure on the write of address 3
    t = 0;
    while (!(bus.rdreq_o && bus.mem_addr_o == 10'd3) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_addr3", 64'(t < 200), 64'd1);
    sink_rdy = 1'b0;
    repeat (2) @(negedge clk);
    stable = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.mem_we_o && bus.mem_addr_o == 10'd3 && bus.mem_data_o == 32'h1000_0003) stable++;
      if (k == 5) sink_rdy = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    check_eq("stall_stable", stable, 6);
    check_eq("stall_addr_adv", bus.mem_addr_o, 10'd4);
    check_eq("stall_we_off", bus.mem_we_o, 1'b0);

    // FIFO drains after 10 words
    t = 0;
    while (!(bus.mem_addr_o == 10'd10 && !bus.mem_we_o && bus.rdempty_i) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_wait", 64'(t < 200), 64'd1);
    check_eq("cs4_done", bus2.done_o, 1'b1);
    check_eq("cs4_addr", bus2.mem_addr_o, 10'd3);
    check_eq("cs4_we", bus2.mem_we_o, 1'b0);
    check_eq("cs4_sum", bus2.checksum_o, EXP_CS_SMALL);

    bad = 0;
    repeat (20) begin
      if (bus.rdreq_o || bus.mem_we_o || bus.done_o || bus.mem_addr_o != 10'd10) bad++;
      @(negedge clk);
    end
    check_eq("wait_idle", bad, 0);

    for (int i = 10; i < 256; i++) fifo_mem[i] = 32'h1000_0000 + 32'(i);
    wr_ptr = 256;

    t = 0;
    while (!bus.done_o && t < 1500) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_done", 64'(t < 1500), 64'd1);
    check_eq("write_count", wr_n, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (log_addr[i] != AW'(i) || log_data[i] != 32'h1000_0000 + 32'(i)) bad++;
    end
    check_eq("write_seq", bad, 0);
    check_eq("gap_stall", log_cyc[3] - log_cyc[2], 8);
    bad = 0;
    for (int i = 1; i < 256; i++) begin
      if (i != 3 && i != 10 && (log_cyc[i] - log_cyc[i-1]) != 3) bad++;
    end
    check_eq("gap_nostall", bad, 0);
    check_eq("done_addr", bus.mem_addr_o, 10'd255);
    check_eq("done_cs", bus.checksum_o, EXP_CS_MAIN);

    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rdreq_o || bus.mem_we_o || !bus.done_o) bad++;
    end
    check_eq("done_parked", bad, 0);
    check_eq("no_underflow", underflow_n, 0);

    // restart, then reset during LATCH at address 50
    for (int j = 0; j < 60; j++) fifo_mem[256 + j] = 32'h2000_0000 + 32'(j);
    wr_ptr  = 316;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_eq("rst2_done", bus.done_o, 1'b0);
    check_eq("rst2_addr", bus.mem_addr_o, 10'd0);
    t = 0;
    while (!(bus.rdreq_o && bus.mem_addr_o == 10'd50) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_addr50", 64'(t < 400), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_addr", bus.mem_addr_o, 10'd0);
    check_eq("midrst_done", bus.done_o, 1'b0);
    check_eq("midrst_we", bus.mem_we_o, 1'b0);
    check_eq("midrst_rdreq", bus.rdreq_o, 1'b0);
    reset_n = 1'b1;

    t = 0;
    while (wr_n < 315 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_restart_end", 64'(t < 300), 64'd1);
    check_eq("pre_rst_last", {log_addr[305], log_data[305]}, {10'd49, 32'h2000_0031});
    check_eq("restart_first", {log_addr[306], log_data[306]}, {10'd0, 32'h2000_0033});
    check_eq("restart_last", {log_addr[314], log_data[314]}, {10'd8, 32'h2000_003B});
    check_eq("restart_wait_addr", bus.mem_addr_o, 10'd9);
    check_eq("restart_wait_rdreq", bus.rdreq_o, 1'b0);
    check_eq("final_underflow", underflow_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
